cmd_sequencer: RTL and testbench
================================

Name: cmd_sequencer

Overview:
- Parametrised command sequencer for the cartridge link.
- Consumes decoded host frames (command, address, data, received checksum) together with the locally computed CRC, then validates the checksum.
- Executes INIT/WRITE/READ/STATUS against the cart RAM port and returns a one-byte response over a valid/ready handshake.
- Sits between the frame deserialiser/CRC engine and the cart RAM; generalises the single-purpose init-then-run controller to configurable address width, clear depth, CRC mode and response codes.

Parameters:
- ADDR_W, 16, RAM address width.
- CLEAR_WORDS, 256, words written by INIT starting at address 0 (1..2**ADDR_W).
- INIT_FILL, 8'h00, fill value written by INIT.
- CRC_MODE, 0, 0 = CRC-8 (compare bits [7:0] only), 1 = CRC-16 (compare [15:0]).
- ACK_CODE, 8'hA5, success response.
- NAK_CODE, 8'h5A, checksum-mismatch response.
- ERR_CODE, 8'hEE, unknown command or command issued before INIT.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_valid  in  1  one-cycle pulse: frame fields below are valid.
- frame_cmd  in  8  command byte: 01 INIT, 02 WRITE, 03 READ, 04 STATUS.
- frame_addr  in  ADDR_W  target address.
- frame_data  in  8  write data.
- frame_crc  in  16  checksum received in the frame.
- calc_crc  in  16  checksum computed locally over the frame.
- rx_en  out  1  high when a frame is accepted; feeds deserialiser/CRC enables.
- cmd_reset  out  1  one-cycle pulse clearing the deserialiser.
- crc_reset  out  1  one-cycle pulse clearing the CRC engine.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  8  RAM read data, valid exactly 1 cycle after ram_re.
- resp_valid  out  1  response byte valid.
- resp_byte  out  8  response byte.
- resp_ready  in  1  downstream accepts the response.
- busy  out  1  frame in progress.
- initialized  out  1  sticky; set when INIT completes.
- dropped  out  1  sticky; set when a frame_valid arrives while busy.

Behaviour:
- Reset: every output and register is 0 except rx_en = 1; state = AWAIT_INIT.
  - Reset is asynchronous. Asserting it mid-operation immediately drops ram_we, ram_re and resp_valid and clears initialized and dropped.
- States:
  - AWAIT_INIT, IDLE: rx_en = 1, busy = 0.
  - CHECK, INIT_RAM, EXEC_WR, EXEC_RD, RD_WAIT, RESPOND, CLEANUP: rx_en = 0, busy = 1.
- Accept: frame_valid in AWAIT_INIT or IDLE latches all frame fields and goes to CHECK on the next edge.
  - frame_valid in any other state is ignored and sets dropped.
- CHECK (1 cycle), in priority order:
  1. CRC mismatch (width per CRC_MODE) -> RESPOND, byte = NAK_CODE.
  2. Not initialized and cmd != 01 -> RESPOND, byte = ERR_CODE.
  3. cmd 01 -> INIT_RAM.
  4. cmd 02 -> EXEC_WR.
  5. cmd 03 -> EXEC_RD.
  6. cmd 04 -> RESPOND, byte = {initialized, CRC_MODE[0], dropped, 5'b0}.
  7. Any other cmd -> RESPOND, byte = ERR_CODE.
- INIT_RAM: ram_we = 1 for exactly CLEAR_WORDS consecutive cycles, ram_addr = 0..CLEAR_WORDS-1, ram_wdata = INIT_FILL.
  - On the last write, set initialized and go to RESPOND ACK_CODE.
  - INIT issued when already initialized re-runs the clear.
  - Counter width is ADDR_W+1 so CLEAR_WORDS = 2**ADDR_W does not wrap early.
- EXEC_WR: one cycle with ram_we = 1, ram_addr = latched address, ram_wdata = latched data -> RESPOND ACK_CODE.
- EXEC_RD: one cycle with ram_re = 1 -> RD_WAIT (1 cycle) captures ram_rdata -> RESPOND with byte = read data.
- RESPOND: resp_valid = 1, resp_byte held stable until the cycle where resp_valid && resp_ready; then go to CLEANUP.
  - No timeout.
- CLEANUP (1 cycle): cmd_reset = crc_reset = 1, then go to IDLE if initialized, else AWAIT_INIT.
- Latency from frame_valid to resp_valid:
  - WRITE, STATUS, NAK, ERR: 2/3 cycles; STATUS/NAK/ERR is 2, WRITE is 3.
  - READ: 4 cycles.
  - INIT: CLEAR_WORDS+2 cycles.
- ram_we and ram_re are never high in the same cycle.
- ram_we is never high outside INIT_RAM and EXEC_WR.

Test Plan:
- Reset, then WRITE 02 with addr 0010, data 3C and good CRC -> no RAM write; resp_byte EE; after the handshake, cmd_reset/crc_reset pulse and state returns to AWAIT_INIT.
- INIT with CLEAR_WORDS = 4, good CRC -> ram_we on 4 cycles at addrs 0..3 with data 00; resp_byte A5; initialized = 1.
- After INIT: WRITE addr 0002 data 3C, then READ addr 0002 -> responses A5 then 3C; READ resp_valid exactly 4 cycles after frame_valid.
- CRC_MODE = 0, frame_crc 12AB vs calc_crc 34AB -> treated as a match. CRC_MODE = 1, same values -> resp_byte 5A and no RAM access.
- Second frame_valid while waiting in RESPOND with resp_ready held 0 for 5 cycles -> frame ignored; dropped = 1; STATUS then returns A0 (CRC_MODE = 0); resp_byte stable throughout the stall.
- rst_n asserted in the middle of INIT_RAM -> ram_we falls without waiting for clk; initialized = 0; next WRITE returns EE.

Source files
------------

// File: rtl/cmd_sequencer.sv
// Host-command sequencer for the cartridge link: checks frame CRC, runs INIT/WRITE/READ/STATUS on cart RAM, returns one response byte.
// Latency frame_valid->resp_valid: 2 (STATUS/NAK/ERR), 3 (WRITE), 4 (READ), CLEAR_WORDS+2 (INIT); frames arriving while busy are dropped and flagged; resp held until resp_ready.
module cmd_sequencer #(
    parameter int          ADDR_W      = 16,
    parameter int          CLEAR_WORDS = 256,
    parameter logic [7:0]  INIT_FILL   = 8'h00,
    parameter int          CRC_MODE    = 0,
    parameter logic [7:0]  ACK_CODE    = 8'hA5,
    parameter logic [7:0]  NAK_CODE    = 8'h5A,
    parameter logic [7:0]  ERR_CODE    = 8'hEE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_valid,
    input  logic [7:0]        frame_cmd,
    input  logic [ADDR_W-1:0] frame_addr,
    input  logic [7:0]        frame_data,
    input  logic [15:0]       frame_crc,
    input  logic [15:0]       calc_crc,
    output logic              rx_en,
    output logic              cmd_reset,
    output logic              crc_reset,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [7:0]        ram_rdata,
    output logic              resp_valid,
    output logic [7:0]        resp_byte,
    input  logic              resp_ready,
    output logic              busy,
    output logic              initialized,
    output logic              dropped
);

    typedef enum logic [3:0] {
        AWAIT_INIT, IDLE, CHECK, INIT_RAM, EXEC_WR, EXEC_RD, RD_WAIT, RESPOND, CLEANUP
    } state_t;

    localparam logic            MODE_BIT = 1'(CRC_MODE);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(CLEAR_WORDS - 1);

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [15:0]       fcrc_q, fcrc_d;
    logic [15:0]       ccrc_q, ccrc_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        resp_q, resp_d;
    logic              initialized_q, initialized_d;
    logic              dropped_q, dropped_d;
    logic              crc_ok;

    assign crc_ok = MODE_BIT ? (fcrc_q == ccrc_q) : (fcrc_q[7:0] == ccrc_q[7:0]);

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        data_d        = data_q;
        fcrc_d        = fcrc_q;
        ccrc_d        = ccrc_q;
        cnt_d         = cnt_q;
        resp_d        = resp_q;
        initialized_d = initialized_q;
        dropped_d     = dropped_q;
        rx_en         = 1'b0;
        busy          = 1'b1;
        cmd_reset     = 1'b0;
        crc_reset     = 1'b0;
        ram_addr      = '0;
        ram_wdata     = '0;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        resp_valid    = 1'b0;

        case (state_q)
            AWAIT_INIT, IDLE: begin
                rx_en = 1'b1;
                busy  = 1'b0;
                if (frame_valid) begin
                    cmd_d   = frame_cmd;
                    addr_d  = frame_addr;
                    data_d  = frame_data;
                    fcrc_d  = frame_crc;
                    ccrc_d  = calc_crc;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = RESPOND;
                if (!crc_ok) begin
                    resp_d = NAK_CODE;
                end else if (!initialized_q && cmd_q != 8'h01) begin
                    resp_d = ERR_CODE;
                end else begin
                    case (cmd_q)
                        8'h01: begin
                            cnt_d   = '0;
                            state_d = INIT_RAM;
                        end
                        8'h02:   state_d = EXEC_WR;
                        8'h03:   state_d = EXEC_RD;
                        8'h04:   resp_d  = {initialized_q, MODE_BIT, dropped_q, 5'b0};
                        default: resp_d  = ERR_CODE;
                    endcase
                end
            end
            INIT_RAM: begin
                ram_we    = 1'b1;
                ram_addr  = cnt_q[ADDR_W-1:0];
                ram_wdata = INIT_FILL;
                if (cnt_q == LAST_IDX) begin
                    initialized_d = 1'b1;
                    resp_d        = ACK_CODE;
                    state_d       = RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EXEC_WR: begin
                ram_we    = 1'b1;
                ram_addr  = addr_q;
                ram_wdata = data_q;
                resp_d    = ACK_CODE;
                state_d   = RESPOND;
            end
            EXEC_RD: begin
                ram_re   = 1'b1;
                ram_addr = addr_q;
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                // RAM returns data one cycle after the strobe
                resp_d  = ram_rdata;
                state_d = RESPOND;
            end
            RESPOND: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = CLEANUP;
            end
            CLEANUP: begin
                cmd_reset = 1'b1;
                crc_reset = 1'b1;
                state_d   = initialized_q ? IDLE : AWAIT_INIT;
            end
            default: state_d = AWAIT_INIT;
        endcase

        if (frame_valid && busy) dropped_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= AWAIT_INIT;
            cmd_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            fcrc_q        <= '0;
            ccrc_q        <= '0;
            cnt_q         <= '0;
            resp_q        <= '0;
            initialized_q <= 1'b0;
            dropped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            fcrc_q        <= fcrc_d;
            ccrc_q        <= ccrc_d;
            cnt_q         <= cnt_d;
            resp_q        <= resp_d;
            initialized_q <= initialized_d;
            dropped_q     <= dropped_d;
        end
    end

    assign resp_byte   = resp_q;
    assign initialized = initialized_q;
    assign dropped     = dropped_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench for cmd_sequencer: directed frames push expected response bytes, monitors pop on handshake.
module tb_cmd_sequencer;

    localparam int ADDR_W = 16;
    localparam int CW     = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_valid = 1'b0, frame_valid1 = 1'b0;
    logic [7:0]        frame_cmd = '0, frame_data = '0;
    logic [ADDR_W-1:0] frame_addr = '0;
    logic [15:0]       frame_crc = '0, calc_crc = '0;
    logic              resp_ready = 1'b1, resp_ready1 = 1'b1;
    logic [7:0]        ram_rdata = '0;

    logic              rx_en, cmd_reset, crc_reset, ram_we, ram_re, resp_valid, busy, initialized, dropped;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata, resp_byte;

    logic              rx_en1, cmd_reset1, crc_reset1, ram_we1, ram_re1, resp_valid1, busy1, initialized1, dropped1;
    logic [ADDR_W-1:0] ram_addr1;
    logic [7:0]        ram_wdata1, resp_byte1;

    int vectors = 0, miscompares = 0;
    int overlap = 0, acc1 = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp1_q[$];
    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    logic [7:0]  mem [0:255];

    cmd_sequencer #(.ADDR_W(ADDR_W), .CLEAR_WORDS(CW), .CRC_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .frame_cmd(frame_cmd),
        .frame_addr(frame_addr), .frame_data(frame_data), .frame_crc(frame_crc), .calc_crc(calc_crc),
        .rx_en(rx_en), .cmd_reset(cmd_reset), .crc_reset(crc_reset), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
        .resp_valid(resp_valid), .resp_byte(resp_byte), .resp_ready(resp_ready),
        .busy(busy), .initialized(initialized), .dropped(dropped));

    cmd_sequencer #(.ADDR_W(ADDR_W), .CLEAR_WORDS(CW), .CRC_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid1), .frame_cmd(frame_cmd),
        .frame_addr(frame_addr), .frame_data(frame_data), .frame_crc(frame_crc), .calc_crc(calc_crc),
        .rx_en(rx_en1), .cmd_reset(cmd_reset1), .crc_reset(crc_reset1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_we(ram_we1), .ram_re(ram_re1), .ram_rdata(8'h00),
        .resp_valid(resp_valid1), .resp_byte(resp_byte1), .resp_ready(resp_ready1),
        .busy(busy1), .initialized(initialized1), .dropped(dropped1));

    always #5 clk = ~clk;

    // Cart RAM model: synchronous write, read data one cycle after ram_re
    initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Response monitors and RAM activity logging
    always @(negedge clk) begin
        if (ram_we && ram_re) overlap++;
        if (ram_we) begin
            wr_a.push_back(ram_addr);
            wr_d.push_back(ram_wdata);
        end
        if (ram_we1 || ram_re1) acc1++;
        if (resp_valid && !resp_ready && exp_q.size() > 0)
            chk("resp_stable", resp_byte, exp_q[0]);
        if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
            else chk("resp_byte", resp_byte, exp_q.pop_front());
        end
        if (resp_valid1 && resp_ready1) begin
            if (exp1_q.size() == 0) chk("unexpected_resp1", 1, 0);
            else chk("resp_byte1", resp_byte1, exp1_q.pop_front());
        end
    end

    task automatic send(input logic [7:0] cmd, input logic [15:0] addr, input logic [7:0] data,
                        input logic [15:0] fcrc, input logic [15:0] ccrc,
                        input logic [7:0] exp_b, input int exp_lat, input int stall);
        int  lat;
        bit  got, pulse;
        @(posedge clk); #2;
        frame_cmd = cmd; frame_addr = addr; frame_data = data;
        frame_crc = fcrc; calc_crc = ccrc;
        exp_q.push_back(exp_b);
        resp_ready = (stall == 0);
        frame_valid = 1'b1;
        lat = 0; got = 0;
        while (!got && lat < 300) begin
            @(posedge clk); #2;
            frame_valid = 1'b0;
            lat++;
            got = resp_valid;
        end
        chk("latency", lat, exp_lat);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #2;
            frame_valid = (i == 1);
            if (i == 1) begin
                frame_cmd = 8'h02; frame_addr = 16'h0005; frame_data = 8'h77;
                frame_crc = 16'h0000; calc_crc = 16'h0000;
            end
        end
        frame_valid = 1'b0;
        resp_ready = 1'b1;
        pulse = 0; lat = 0;
        do begin
            @(posedge clk); #2;
            if (cmd_reset && crc_reset) pulse = 1;
            lat++;
        end while (!rx_en && lat < 50);
        chk("cleanup_pulse", pulse, 1);
        chk("back_to_rx", rx_en, 1);
    endtask

    initial begin
        int lat;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        #12;
        chk("reset_outs", {rx_en, busy, ram_we, ram_re, resp_valid, initialized, dropped, cmd_reset, crc_reset, resp_byte},
            {9'b1_0000_0000, 8'h00});
        @(posedge clk); #2; rst_n = 1'b1;

        // WRITE before INIT: error, no RAM write, back to AWAIT_INIT
        wr_a.delete(); wr_d.delete();
        send(8'h02, 16'h0010, 8'h3C, 16'h0000, 16'h0000, 8'hEE, 2, 0);
        chk("pre_init_no_write", wr_a.size(), 0);
        chk("still_uninit", initialized, 0);

        // INIT clears CW words at addresses 0..CW-1
        wr_a.delete(); wr_d.delete();
        send(8'h01, 16'h0000, 8'h00, 16'h0000, 16'h0000, 8'hA5, CW + 2, 0);
        chk("init_wr_cnt", wr_a.size(), CW);
        for (int i = 0; i < CW && i < wr_a.size(); i++) begin
            chk("init_addr", wr_a[i], i);
            chk("init_data", wr_d[i], 8'h00);
        end
        chk("initialized", initialized, 1);

        // WRITE with upper CRC byte differing: CRC-8 mode treats as match
        wr_a.delete(); wr_d.delete();
        send(8'h02, 16'h0002, 8'h3C, 16'h12AB, 16'h34AB, 8'hA5, 3, 0);
        chk("wr_cnt", wr_a.size(), 1);
        if (wr_a.size() > 0) begin
            chk("wr_addr", wr_a[0], 16'h0002);
            chk("wr_data", wr_d[0], 8'h3C);
        end
        send(8'h03, 16'h0002, 8'h00, 16'h0000, 16'h0000, 8'h3C, 4, 0);

        // CRC-16 instance sees the same CRCs as a mismatch
        @(posedge clk); #2;
        frame_cmd = 8'h02; frame_addr = 16'h0002; frame_data = 8'h99;
        frame_crc = 16'h12AB; calc_crc = 16'h34AB;
        exp1_q.push_back(8'h5A);
        frame_valid1 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #2;
            frame_valid1 = 1'b0;
            lat++;
        end while (!resp_valid1 && lat < 50);
        chk("nak_latency", lat, 2);
        lat = 0;
        do begin
            @(posedge clk); #2;
            lat++;
        end while (!rx_en1 && lat < 50);
        chk("nak_no_ram", acc1, 0);

        send(8'h04, 16'h0000, 8'h00, 16'h0000, 16'h0000, 8'h80, 2, 0);

        // Stall the response 5 cycles and inject a frame: it must be dropped
        wr_a.delete(); wr_d.delete();
        send(8'h03, 16'h0002, 8'h00, 16'h0000, 16'h0000, 8'h3C, 4, 5);
        chk("dropped", dropped, 1);
        chk("drop_no_write", wr_a.size(), 0);
        send(8'h04, 16'h0000, 8'h00, 16'h0000, 16'h0000, 8'hA0, 2, 0);
        send(8'h07, 16'h0000, 8'h00, 16'h0000, 16'h0000, 8'hEE, 2, 0);

        // Asynchronous reset in the middle of INIT_RAM
        @(posedge clk); #2;
        frame_cmd = 8'h01; frame_crc = 16'h0000; calc_crc = 16'h0000;
        frame_valid = 1'b1;
        @(posedge clk); #2; frame_valid = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("mid_init_we", ram_we, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_we", ram_we, 0);
        chk("async_rst_flags", {initialized, dropped, resp_valid, rx_en}, 4'b0001);
        @(posedge clk); #2; rst_n = 1'b1;
        wr_a.delete(); wr_d.delete();
        send(8'h02, 16'h0010, 8'h3C, 16'h0000, 16'h0000, 8'hEE, 2, 0);
        chk("post_rst_no_write", wr_a.size(), 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_q.size() + exp1_q.size(), 0);
        chk("we_re_overlap", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
